stf_stream_gen: RTL and testbench

- Parametrised successor to the fixed 16-entry short-training-field sample table.
- On a start pulse, streams the complete 802.11 STF burst (NUM_REP periods of 16 complex samples) over a valid/ready handshake.
- Supports configurable I/Q width, runtime gain attenuation and optional half-amplitude edge windowing.
- Sits ahead of the TX sample mux in openofdm_tx. Replaces direct table reads by the preamble sequencer.

---
 rtl/stf_stream_gen.sv | 193 +++++++++++++++++++
 tb/tb_stf_stream_gen.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stf_stream_gen.sv
// stf_stream_gen: streams an 802.11 short-training-field burst (NUM_REP periods
// of the 16-sample STF) over a valid/ready handshake. Samples are rescaled to
// IQ_W bits, attenuated by a latched gain shift, and the first and last sample
// of the burst can be halved to soften the burst edges.
module stf_stream_gen #(
    parameter int IQ_W    = 16,
    parameter int NUM_REP = 10,
    parameter int WINDOW  = 1
) (
    input  logic                   clk,
    input  logic                   phy_tx_arestn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [1:0]             gain_shift,
    output logic signed [IQ_W-1:0] o_i,
    output logic signed [IQ_W-1:0] o_q,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_last,
    output logic                   busy,
    output logic                   done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    // Rescaling is done in a 40-bit field: left-justify the 16-bit value by 24
    // bits, then one arithmetic right shift lands it at IQ_W bits. This covers
    // both the widening (exact) and narrowing (floor) cases with one path.
    localparam int         SCALE_SHR = 40 - IQ_W;
    localparam logic [3:0] REP_LAST  = 4'(NUM_REP - 1);

    // 16-entry STF base table, {I, Q} as 16-bit two's complement
    function automatic logic [31:0] stf_base(input logic [3:0] idx);
        logic [31:0] v;
        case (idx)
            4'd0:    v = {16'hfd0e, 16'hfd0e};
            4'd1:    v = {16'hfe68, 16'h03d9};
            4'd2:    v = {16'h042a, 16'h0000};
            4'd3:    v = {16'hfe68, 16'hfc27};
            4'd4:    v = {16'hfd0e, 16'h02f2};
            4'd5:    v = {16'h03d9, 16'h0198};
            4'd6:    v = {16'h0000, 16'hfbd6};
            4'd7:    v = {16'hfc27, 16'h0198};
            4'd8:    v = {16'h02f2, 16'h02f2};
            4'd9:    v = {16'h0198, 16'hfc27};
            4'd10:   v = {16'hfbd6, 16'h0000};
            4'd11:   v = {16'h0198, 16'h03d9};
            4'd12:   v = {16'h02f2, 16'hfd0e};
            4'd13:   v = {16'hfc27, 16'hfe68};
            4'd14:   v = {16'h0000, 16'h042a};
            default: v = {16'h03d9, 16'hfe68};
        endcase
        return v;
    endfunction

    // Width conversion, gain attenuation and optional edge halving of one component
    function automatic logic [IQ_W-1:0] scale(input logic [15:0] b, input logic [1:0] g,
                                              input logic win);
        logic signed [39:0] w;
        w = {{24{b[15]}}, b};
        w = (w <<< 24) >>> SCALE_SHR;
        w = w >>> g;
        if (win) begin
            w = w >>> 1;
        end
        return w[IQ_W-1:0];
    endfunction

    logic [1:0]            state_q, state_d;
    logic [3:0]            idx_q, idx_d;
    logic [3:0]            rep_q, rep_d;
    logic [1:0]            gain_q, gain_d;
    logic signed [IQ_W-1:0] i_q, i_d;
    logic signed [IQ_W-1:0] q_q, q_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [3:0]  nxt_idx;
    logic [3:0]  nxt_rep;
    logic        nxt_last;
    logic [31:0] nxt_base;
    logic [31:0] first_base;

    // Look-ahead to the sample that follows the one currently presented
    always_comb begin
        nxt_idx    = idx_q + 4'd1;
        nxt_rep    = (idx_q == 4'd15) ? rep_q + 4'd1 : rep_q;
        nxt_last   = (nxt_rep == REP_LAST) && (nxt_idx == 4'd15);
        nxt_base   = stf_base(nxt_idx);
        first_base = stf_base(4'd0);
    end

    // Next-state logic: abort overrides everything, otherwise IDLE/RUN/FIN sequencing
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        gain_d  = gain_q;
        i_d     = i_q;
        q_d     = q_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            idx_d   = 4'd0;
            rep_d   = 4'd0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        // first sample is presented straight away, using the live gain input
                        state_d = S_RUN;
                        gain_d  = gain_shift;
                        idx_d   = 4'd0;
                        rep_d   = 4'd0;
                        i_d     = scale(first_base[31:16], gain_shift, WINDOW != 0);
                        q_d     = scale(first_base[15:0], gain_shift, WINDOW != 0);
                        valid_d = 1'b1;
                        last_d  = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
                S_RUN: begin
                    if (valid_q && i_ready) begin
                        if (last_q) begin
                            state_d = S_FIN;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            busy_d  = 1'b0;
                        end else begin
                            idx_d  = nxt_idx;
                            rep_d  = nxt_rep;
                            i_d    = scale(nxt_base[31:16], gain_q, (WINDOW != 0) && nxt_last);
                            q_d    = scale(nxt_base[15:0], gain_q, (WINDOW != 0) && nxt_last);
                            last_d = nxt_last;
                        end
                    end
                end
                S_FIN: begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge phy_tx_arestn) begin
        if (!phy_tx_arestn) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            rep_q   <= 4'd0;
            gain_q  <= 2'd0;
            i_q     <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            gain_q  <= gain_d;
            i_q     <= i_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_i     = i_q;
    assign o_q     = q_q;
    assign o_valid = valid_q;
    assign o_last  = last_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_stf_stream_gen.sv
// tb_stf_stream_gen: three differently parameterised stf_stream_gen instances
// share one stimulus stream; a burst-level reference model predicts every
// output each cycle.
module tb_stf_stream_gen;

    localparam int NK = 3;
    localparam int NREP  [NK] = '{10, 2, 1};
    localparam int WIDTH [NK] = '{16, 12, 18};
    localparam int WIN   [NK] = '{1, 0, 1};

    localparam logic [15:0] TI [16] = '{16'hfd0e, 16'hfe68, 16'h042a, 16'hfe68,
                                        16'hfd0e, 16'h03d9, 16'h0000, 16'hfc27,
                                        16'h02f2, 16'h0198, 16'hfbd6, 16'h0198,
                                        16'h02f2, 16'hfc27, 16'h0000, 16'h03d9};
    localparam logic [15:0] TQ [16] = '{16'hfd0e, 16'h03d9, 16'h0000, 16'hfc27,
                                        16'h02f2, 16'h0198, 16'hfbd6, 16'h0198,
                                        16'h02f2, 16'hfc27, 16'h0000, 16'h03d9,
                                        16'hfd0e, 16'hfe68, 16'h042a, 16'hfe68};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       ready = 1'b1;
    logic [1:0] gain = 2'd0;

    logic signed [15:0] i0, q0;
    logic signed [11:0] i1, q1;
    logic signed [17:0] i2, q2;
    logic vld [NK];
    logic lst [NK];
    logic bsy [NK];
    logic dne [NK];
    int   oi [NK];
    int   oq [NK];

    int checks = 0;
    int errors = 0;

    // model: m_pos = index of the sample being presented (-1 when none),
    // m_fin counts down 2 (gap cycle) -> 1 (done cycle) -> 0 after the last handshake
    int m_pos  [NK] = '{-1, -1, -1};
    int m_fin  [NK] = '{0, 0, 0};
    int m_gain [NK] = '{0, 0, 0};

    int obs_hs    [NK] = '{0, 0, 0};
    int done_seen [NK] = '{0, 0, 0};
    int obs_i [NK][160];
    int obs_q [NK][160];

    always #5 clk = ~clk;

    stf_stream_gen #(.IQ_W(16), .NUM_REP(10), .WINDOW(1)) u_dut0 (
        .clk(clk), .phy_tx_arestn(rst_n), .start(start), .abort(abort), .gain_shift(gain),
        .o_i(i0), .o_q(q0), .o_valid(vld[0]), .i_ready(ready), .o_last(lst[0]),
        .busy(bsy[0]), .done(dne[0]));

    stf_stream_gen #(.IQ_W(12), .NUM_REP(2), .WINDOW(0)) u_dut1 (
        .clk(clk), .phy_tx_arestn(rst_n), .start(start), .abort(abort), .gain_shift(gain),
        .o_i(i1), .o_q(q1), .o_valid(vld[1]), .i_ready(ready), .o_last(lst[1]),
        .busy(bsy[1]), .done(dne[1]));

    stf_stream_gen #(.IQ_W(18), .NUM_REP(1), .WINDOW(1)) u_dut2 (
        .clk(clk), .phy_tx_arestn(rst_n), .start(start), .abort(abort), .gain_shift(gain),
        .o_i(i2), .o_q(q2), .o_valid(vld[2]), .i_ready(ready), .o_last(lst[2]),
        .busy(bsy[2]), .done(dne[2]));

    always_comb begin
        oi[0] = int'(i0);
        oq[0] = int'(q0);
        oi[1] = int'(i1);
        oq[1] = int'(q1);
        oi[2] = int'(i2);
        oq[2] = int'(q2);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d (0x%08h) want=%0d (0x%08h) t=%0t",
                     tag, $signed(got), got, $signed(exp), exp, $time);
        end
    endtask

    // expected sample value: base * 2^(W-16), floor-divided by 2^(gain + edge + narrowing)
    function automatic int ref_val(input int k, input int pos, input int g, input bit isq);
        int          n;
        int          v;
        int          sh;
        logic [15:0] raw;
        n   = NREP[k] * 16;
        raw = isq ? TQ[pos % 16] : TI[pos % 16];
        v   = int'($signed(raw));
        sh  = g + (((WIN[k] != 0) && (pos == 0 || pos == n - 1)) ? 1 : 0);
        if (WIDTH[k] >= 16) v = v * (1 << (WIDTH[k] - 16));
        else                sh = sh + (16 - WIDTH[k]);
        return v >>> sh;
    endfunction

    function automatic bit all_idle();
        for (int k = 0; k < NK; k++) begin
            if (m_pos[k] >= 0 || m_fin[k] != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // burst-level reference model
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < NK; k++) begin
            if (!rst_n) begin
                m_pos[k]  <= -1;
                m_fin[k]  <= 0;
                m_gain[k] <= 0;
            end else if (abort) begin
                m_pos[k] <= -1;
                m_fin[k] <= 0;
            end else if (m_pos[k] >= 0) begin
                if (ready) begin
                    if (m_pos[k] == NREP[k] * 16 - 1) begin
                        m_pos[k] <= -1;
                        m_fin[k] <= 2;
                    end else begin
                        m_pos[k] <= m_pos[k] + 1;
                    end
                end
            end else if (m_fin[k] == 2) begin
                m_fin[k] <= 1;
            end else begin
                m_fin[k] <= 0;
                if (start) begin
                    m_pos[k]  <= 0;
                    m_gain[k] <= int'(gain);
                end
            end
        end
    end

    // per-cycle comparison of every instance against the model
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < NK; k++) begin
                int p;
                bit ev;
                p  = m_pos[k];
                ev = (p >= 0);
                check_val($sformatf("valid%0d", k), 32'(vld[k]), 32'(ev));
                check_val($sformatf("busy%0d", k), 32'(bsy[k]), 32'(ev));
                check_val($sformatf("last%0d", k), 32'(lst[k]), 32'(ev && p == NREP[k] * 16 - 1));
                check_val($sformatf("done%0d", k), 32'(dne[k]), 32'(m_fin[k] == 1));
                if (ev) begin
                    check_val($sformatf("i%0d_pos%0d", k, p), oi[k], ref_val(k, p, m_gain[k], 1'b0));
                    check_val($sformatf("q%0d_pos%0d", k, p), oq[k], ref_val(k, p, m_gain[k], 1'b1));
                end
                if (vld[k] === 1'b1 && ready) begin
                    if (obs_hs[k] < 160) begin
                        obs_i[k][obs_hs[k]] = oi[k];
                        obs_q[k][obs_hs[k]] = oq[k];
                    end
                    obs_hs[k]++;
                end
                if (dne[k] === 1'b1) begin
                    check_val($sformatf("hs_count%0d", k), obs_hs[k], NREP[k] * 16);
                    $display("dut%0d burst done: handshakes=%0d t=%0t", k, obs_hs[k], $time);
                    done_seen[k]++;
                    obs_hs[k] = 0;
                end
                if (abort || !rst_n) obs_hs[k] = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [1:0] g);
        gain  = g;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_idle(input int budget, input bit rnd);
        int n;
        n = 0;
        while (!all_idle() && n < budget) begin
            if (rnd) ready = ($urandom_range(0, 99) < 70);
            tick();
            n++;
        end
        ready = 1'b1;
        check_val("idle_reached", 32'(all_idle()), 32'd1);
    endtask

    initial begin
        int first_v, vcnt, last_c, done_c, n, dbefore;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < NK; k++) begin
            check_val($sformatf("rst_valid%0d", k), 32'(vld[k]), 32'd0);
            check_val($sformatf("rst_i%0d", k), oi[k], 0);
        end
        rst_n = 1'b1;
        repeat (2) tick();

        // default burst, ready tied high, start in cycle 0
        $display("burst: defaults, ready high");
        first_v = -1; vcnt = 0; last_c = -1; done_c = -1;
        pulse_start(2'd0);
        for (int c = 1; c <= 170; c++) begin
            @(negedge clk);
            if (vld[0] === 1'b1) begin
                vcnt++;
                if (first_v < 0) first_v = c;
            end
            if (lst[0] === 1'b1) last_c = c;
            if (dne[0] === 1'b1) done_c = c;
        end
        tick();
        check_val("first_valid_cycle", first_v, 1);
        check_val("valid_cycles", vcnt, 160);
        check_val("last_cycle", last_c, 160);
        check_val("done_cycle", done_c, 162);
        check_val("s0_i", obs_i[0][0], 32'shffff_fe87);
        check_val("s0_q", obs_q[0][0], 32'shffff_fe87);
        check_val("s1_i", obs_i[0][1], 32'shffff_fe68);
        check_val("s1_q", obs_q[0][1], 32'h0000_03d9);
        check_val("s16_i", obs_i[0][16], 32'shffff_fd0e);
        check_val("s159_i", obs_i[0][159], 32'h0000_01ec);
        check_val("s159_q", obs_q[0][159], 32'shffff_ff34);
        check_val("w18_s2_i", obs_i[2][2], 32'h0000_10a8);
        check_val("w18_s2_q", obs_q[2][2], 0);
        run_until_idle(20, 1'b0);

        // backpressure while sample 5 is presented
        $display("burst: backpressure at sample 5");
        pulse_start(2'd0);
        n = 0;
        while (m_pos[0] != 5 && n < 50) begin tick(); n++; end
        check_val("reach_pos5", m_pos[0], 5);
        ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check_val("bp_hold_i", oi[0], 32'h0000_03d9);
            check_val("bp_hold_q", oq[0], 32'h0000_0198);
            check_val("bp_hold_valid", 32'(vld[0]), 32'd1);
            tick();
        end
        ready = 1'b1;
        run_until_idle(400, 1'b0);

        // narrow width with gain: 0x042a -> 66 -> 16, 0xfd0e -> -48 -> -12
        $display("burst: gain_shift=2");
        pulse_start(2'd2);
        run_until_idle(400, 1'b0);
        check_val("w12_s2_i", obs_i[1][2], 16);
        check_val("w12_s2_q", obs_q[1][2], 0);
        check_val("w12_s0_i", obs_i[1][0], -12);
        check_val("w12_s0_q", obs_q[1][0], -12);

        // randomized gain and ready
        for (int b = 0; b < 5; b++) begin
            $display("burst: random %0d", b);
            pulse_start(2'($urandom_range(0, 3)));
            run_until_idle(1500, 1'b1);
        end

        // abort after 40 handshakes, then restart from index 0
        $display("burst: abort at handshake 40");
        dbefore = done_seen[0];
        pulse_start(2'd1);
        n = 0;
        while (m_pos[0] != 40 && n < 100) begin tick(); n++; end
        check_val("reach_pos40", m_pos[0], 40);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check_val("abort_valid", 32'(vld[0]), 32'd0);
        check_val("abort_busy", 32'(bsy[0]), 32'd0);
        repeat (5) tick();
        check_val("abort_no_done", done_seen[0] - dbefore, 0);
        pulse_start(2'd1);
        @(negedge clk);
        check_val("restart_i", oi[0], ref_val(0, 0, 1, 1'b0));
        run_until_idle(400, 1'b0);

        // start pulses during RUN and in the FIN cycle are ignored
        $display("burst: start during RUN and FIN");
        dbefore = done_seen[0];
        pulse_start(2'd0);
        repeat (20) tick();
        pulse_start(2'd3);
        n = 0;
        while (m_fin[0] != 2 && n < 300) begin tick(); n++; end
        check_val("reach_fin", m_fin[0], 2);
        pulse_start(2'd1);
        run_until_idle(400, 1'b0);
        check_val("single_done", done_seen[0] - dbefore, 1);

        // asynchronous reset in the middle of a burst
        $display("burst: async reset mid-burst");
        pulse_start(2'd3);
        repeat (10) tick();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NK; k++) begin
            check_val($sformatf("arst_valid%0d", k), 32'(vld[k]), 32'd0);
            check_val($sformatf("arst_busy%0d", k), 32'(bsy[k]), 32'd0);
            check_val($sformatf("arst_last%0d", k), 32'(lst[k]), 32'd0);
            check_val($sformatf("arst_done%0d", k), 32'(dne[k]), 32'd0);
            check_val($sformatf("arst_i%0d", k), oi[k], 0);
            check_val($sformatf("arst_q%0d", k), oq[k], 0);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        $display("burst: after reset, random");
        pulse_start(2'($urandom_range(0, 3)));
        run_until_idle(1500, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
